// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-DMA controller and CPU bus arbiter for the NES core. A CPU write to
// DMA_REG_ADDR ($4014) latches a source page. The block then stalls the T65
// through Rdy, takes over the shared bus, and copies the 256 bytes of that page
// into PPU OAM by writing each byte to OAM_DATA_ADDR ($2004). When the last
// byte has been written, it returns the bus to the CPU.
// Runs on CLK_NES, one CPU cycle per clock.
//
// Ports
//   CLK        in   CPU clock, rising edge
//   RESET      in   synchronous, active-high reset
//   CPU_ADDR   in   T65 address (A[15:0])
//   CPU_DO     in   T65 write data
//   CPU_W_R    in   T65 R_W_n (1 = read, 0 = write)
//   CPU_RDY    out  T65 Rdy; 0 stalls the CPU
//   BUS_OWNER  out  1 = DMA drives the shared bus (external mux select)
//   BUS_ADDR   out  DMA bus address
//   BUS_DO     out  DMA write data
//   BUS_WE     out  DMA write strobe
//   BUS_DI     in   memory read data, valid at the edge ending a read cycle
//   DMA_ACTIVE out  high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DO,
   input  logic        CPU_W_R,
   output logic        CPU_RDY,
   output logic        BUS_OWNER,
   output logic [15:0] BUS_ADDR,
   output logic [7:0]  BUS_DO,
   output logic        BUS_WE,
   input  logic [7:0]  BUS_DI,
   output logic        DMA_ACTIVE
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [7:0]  page;
   logic [7:0]  idx;
   logic [7:0]  data;
   logic        parity;
   logic        trigger;
   logic        last_byte;

   // Only a CPU write to the DMA register starts a transfer; reads of it and
   // writes elsewhere are ignored.
   assign trigger   = (CPU_W_R == 1'b0) && (CPU_ADDR == DMA_REG_ADDR);
   assign last_byte = (idx == 8'hFF);

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers. parity free-runs so that the HALT exit can choose
   // whether an ALIGN cycle is needed to put every READ on an even cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         page   <= 8'h00;
         idx    <= 8'h00;
         data   <= 8'h00;
         parity <= 1'b0;
      end else begin
         parity <= ~parity;
         case (state)
            IDLE: begin
               if (trigger) begin
                  page <= CPU_DO;
                  idx  <= 8'h00;
               end
            end
            READ: begin
               data <= BUS_DI;
            end
            WRITE: begin
               if (!last_byte) begin
                  idx <= idx + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and outputs. The outputs depend on the registered state only,
   // so a CPU-side change can never glitch Rdy or the bus select.
   always_comb begin
      state_next = state;
      CPU_RDY    = 1'b1;
      BUS_OWNER  = 1'b0;
      BUS_ADDR   = 16'h0000;
      BUS_DO     = 8'h00;
      BUS_WE     = 1'b0;
      DMA_ACTIVE = 1'b1;

      case (state)
         IDLE: begin
            DMA_ACTIVE = 1'b0;
            if (trigger) begin
               state_next = HALT;
            end
         end
         HALT: begin
            CPU_RDY = 1'b0;
            // The 6502 finishes its write cycles even with Rdy low, so wait for
            // the first read cycle before taking the bus.
            if (CPU_W_R) begin
               state_next = parity ? READ : ALIGN;
            end
         end
         ALIGN: begin
            CPU_RDY    = 1'b0;
            state_next = READ;
         end
         READ: begin
            CPU_RDY    = 1'b0;
            BUS_OWNER  = 1'b1;
            BUS_ADDR   = {page, idx};
            state_next = WRITE;
         end
         WRITE: begin
            CPU_RDY    = 1'b0;
            BUS_OWNER  = 1'b1;
            BUS_ADDR   = OAM_DATA_ADDR;
            BUS_DO     = data;
            BUS_WE     = 1'b1;
            state_next = last_byte ? IDLE : READ;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
